// File: rtl/cavlc_level_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : cavlc_level_ctrl
// Purpose  : Write/replay sequencer for the CAVLC two-port level buffer.
// Revision : 1.0 - initial release
// ============================================================================
module cavlc_level_ctrl #(
  parameter int DATAW = 8,
  parameter int ADDRW = 4,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [4:0]       lvl_num,
  input  logic             lvl_valid,
  input  logic             lvl_pair,
  input  logic [DATAW-1:0] lvl_in0,
  input  logic [DATAW-1:0] lvl_in1,
  output logic             lvl_ready,
  output logic [ADDRW-1:0] buf_waddr,
  output logic [1:0]       buf_we,
  output logic [1:0]       buf_sel,
  output logic [DATAW-1:0] buf_in0,
  output logic [DATAW-1:0] buf_in1,
  output logic [ADDRW-1:0] buf_raddr,
  output logic             buf_re,
  input  logic [DATAW-1:0] buf_out0,
  input  logic [DATAW-1:0] buf_out1,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_pair,
  output logic             out_last,
  output logic [DATAW-1:0] out_lvl0,
  output logic [DATAW-1:0] out_lvl1,
  output logic             blk_done,
  output logic             err
);

  localparam logic [4:0] c_max_num = 5'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_PRIME = 2'd2,
    ST_READ  = 2'd3
  } state_t;

  state_t     r_state;
  logic [4:0] r_num;
  logic [4:0] r_wptr;
  logic [4:0] r_rd_addr;
  logic       r_out_valid;
  logic       r_blk_done;
  logic       r_err;

  logic       w_in_write;
  logic       w_in_read;
  logic       w_fire;
  logic [4:0] w_wrem;
  logic       w_wr_pair;
  logic       w_wr_single;
  logic [4:0] w_wptr_nxt;
  logic [4:0] w_rrem;
  logic       w_last;
  logic       w_rd_adv;
  logic [4:0] w_raddr;

  assign w_in_write  = (r_state == ST_WRITE);
  assign w_in_read   = (r_state == ST_READ);
  assign w_fire      = lvl_valid & w_in_write;
  assign w_wrem      = r_num - r_wptr;
  // A pair only fits when two slots remain; otherwise fall back to a single write
  assign w_wr_pair   = w_fire & lvl_pair & (w_wrem >= 5'd2);
  assign w_wr_single = w_fire & ~w_wr_pair;
  assign w_wptr_nxt  = r_wptr + (w_wr_pair ? 5'd2 : 5'd1);

  assign w_rrem      = r_num - r_rd_addr;
  assign w_last      = (w_rrem <= 5'd2);
  assign w_rd_adv    = w_in_read & out_ready & ~w_last;
  // Presenting the next pair's address on accept keeps one transfer per cycle,
  // while holding it on stall keeps the buffer outputs stable.
  assign w_raddr     = w_rd_adv ? (r_rd_addr + 5'd2) : r_rd_addr;

  assign lvl_ready = w_in_write;
  assign buf_we    = {w_wr_pair, w_fire};
  assign buf_sel   = w_wr_single ? 2'b01 : 2'b00;
  assign buf_waddr = w_in_write ? r_wptr[ADDRW-1:0] : '0;
  assign buf_in0   = lvl_in0;
  assign buf_in1   = lvl_in1;
  assign buf_re    = (r_state == ST_PRIME) | w_in_read;
  assign buf_raddr = w_in_read ? w_raddr[ADDRW-1:0] : '0;

  assign out_valid = r_out_valid;
  assign out_pair  = (w_rrem >= 5'd2);
  assign out_last  = w_last;
  assign out_lvl0  = buf_out0;
  assign out_lvl1  = buf_out1;
  assign blk_done  = r_blk_done;
  assign err       = r_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_num       <= '0;
      r_wptr      <= '0;
      r_rd_addr   <= '0;
      r_out_valid <= 1'b0;
      r_blk_done  <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_blk_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            if (lvl_num == 5'd0) begin
              r_blk_done <= 1'b1;
            end else begin
              if (lvl_num > c_max_num) begin
                r_num <= c_max_num;
                r_err <= 1'b1;
              end else begin
                r_num <= lvl_num;
              end
              r_wptr  <= '0;
              r_state <= ST_WRITE;
            end
          end
        end
        ST_WRITE: begin
          if (w_fire) begin
            r_wptr <= w_wptr_nxt;
            if (w_wr_single & lvl_pair)
              r_err <= 1'b1;
            if (w_wptr_nxt == r_num)
              r_state <= ST_PRIME;
          end
        end
        ST_PRIME: begin
          r_rd_addr   <= '0;
          r_out_valid <= 1'b1;
          r_state     <= ST_READ;
        end
        ST_READ: begin
          if (out_ready) begin
            if (w_last) begin
              r_out_valid <= 1'b0;
              r_blk_done  <= 1'b1;
              r_state     <= ST_IDLE;
            end else begin
              r_rd_addr <= r_rd_addr + 5'd2;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cavlc_level_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_cavlc_level_ctrl
// Purpose  : Scoreboard bench for cavlc_level_ctrl with a behavioural buffer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cavlc_level_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [4:0] lvl_num;
  logic       lvl_valid;
  logic       lvl_pair;
  logic [7:0] lvl_in0;
  logic [7:0] lvl_in1;
  logic       lvl_ready;
  logic [3:0] buf_waddr;
  logic [1:0] buf_we;
  logic [1:0] buf_sel;
  logic [7:0] buf_in0;
  logic [7:0] buf_in1;
  logic [3:0] buf_raddr;
  logic       buf_re;
  logic [7:0] buf_out0;
  logic [7:0] buf_out1;
  logic       out_valid;
  logic       out_ready;
  logic       out_pair;
  logic       out_last;
  logic [7:0] out_lvl0;
  logic [7:0] out_lvl1;
  logic       blk_done;
  logic       err;

  always #5 clk = ~clk;

  cavlc_level_ctrl #(.DATAW(8), .ADDRW(4), .DEPTH(16)) dut (
    .clk(clk), .rst(rst), .start(start), .lvl_num(lvl_num),
    .lvl_valid(lvl_valid), .lvl_pair(lvl_pair), .lvl_in0(lvl_in0), .lvl_in1(lvl_in1),
    .lvl_ready(lvl_ready), .buf_waddr(buf_waddr), .buf_we(buf_we), .buf_sel(buf_sel),
    .buf_in0(buf_in0), .buf_in1(buf_in1), .buf_raddr(buf_raddr), .buf_re(buf_re),
    .buf_out0(buf_out0), .buf_out1(buf_out1), .out_valid(out_valid), .out_ready(out_ready),
    .out_pair(out_pair), .out_last(out_last), .out_lvl0(out_lvl0), .out_lvl1(out_lvl1),
    .blk_done(blk_done), .err(err)
  );

  // Two-port level buffer: single/pair write, registered pair read
  logic [7:0] mem [0:15];
  initial for (int i = 0; i < 16; i++) mem[i] = 8'h00;
  always @(posedge clk) begin
    if (buf_we[0]) mem[buf_waddr] <= buf_sel[0] ? buf_in0 : buf_in0;
    if (buf_we[1]) mem[buf_waddr + 4'd1] <= buf_in1;
    if (buf_re) begin
      buf_out0 <= mem[buf_raddr];
      buf_out1 <= mem[buf_raddr + 4'd1];
    end
  end

  typedef struct packed {
    logic [7:0] l0;
    logic [7:0] l1;
    logic       pr;
    logic       last;
  } xfer_t;

  xfer_t      q[$];
  xfer_t      m_e;
  int         n_vec  = 0;
  int         n_err  = 0;
  int         n_done = 0;
  logic [7:0] exp_mem [0:15];
  int         exp_wptr;

  always @(negedge clk) begin
    if (!rst) begin
      if (blk_done) n_done++;
      if (out_valid) begin
        n_vec++;
        if (q.size() == 0) begin
          n_err++;
          $display("FAIL out_unexpected: got valid lvl0=%h last=%b, required no transfer", out_lvl0, out_last);
        end else begin
          m_e = q[0];
          if (out_lvl0 !== m_e.l0 || out_pair !== m_e.pr || out_last !== m_e.last ||
              (m_e.pr && out_lvl1 !== m_e.l1)) begin
            n_err++;
            $display("FAIL out_xfer: got lvl0=%h lvl1=%h pair=%b last=%b, required lvl0=%h lvl1=%h pair=%b last=%b",
                     out_lvl0, out_lvl1, out_pair, out_last, m_e.l0, m_e.l1, m_e.pr, m_e.last);
          end
          if (out_ready) void'(q.pop_front());
        end
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; lvl_num = '0; lvl_valid = 1'b0; lvl_pair = 1'b0;
    lvl_in0 = '0; lvl_in1 = '0; out_ready = 1'b0;
    q.delete();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_vec++;
    if (out_valid !== 1'b0 || lvl_ready !== 1'b0 || blk_done !== 1'b0) begin
      n_err++;
      $display("FAIL reset_ctrl: got valid=%b ready=%b done=%b, required 0 0 0", out_valid, lvl_ready, blk_done);
    end
    n_vec++;
    if (buf_we !== 2'b00 || buf_waddr !== 4'd0 || buf_raddr !== 4'd0 || buf_re !== 1'b0) begin
      n_err++;
      $display("FAIL reset_buf: got we=%b waddr=%0d raddr=%0d re=%b, required 00 0 0 0", buf_we, buf_waddr, buf_raddr, buf_re);
    end
    n_vec++;
    if (err !== 1'b0) begin
      n_err++;
      $display("FAIL reset_err: got %b, required 0", err);
    end
  endtask

  task automatic start_blk(input logic [4:0] n, input logic exp_rdy);
    @(posedge clk); #1;
    start = 1'b1; lvl_num = n;
    @(posedge clk); #1;
    start = 1'b0;
    exp_wptr = 0;
    n_vec++;
    if (lvl_ready !== exp_rdy) begin
      n_err++;
      $display("FAIL start_ready: got %b, required %b", lvl_ready, exp_rdy);
    end
  endtask

  task automatic wr(input logic pr, input logic [7:0] a, input logic [7:0] b, input int num);
    logic [1:0] ewe;
    ewe = (pr && (num - exp_wptr) >= 2) ? 2'b11 : 2'b01;
    lvl_valid = 1'b1; lvl_pair = pr; lvl_in0 = a; lvl_in1 = b;
    #1;
    n_vec++;
    if (buf_we !== ewe || buf_waddr !== 4'(exp_wptr) || (ewe == 2'b01 && buf_sel !== 2'b01)) begin
      n_err++;
      $display("FAIL write: got we=%b waddr=%0d sel=%b, required we=%b waddr=%0d", buf_we, buf_waddr, buf_sel, ewe, exp_wptr);
    end
    exp_mem[exp_wptr] = a;
    if (ewe == 2'b11) exp_mem[exp_wptr + 1] = b;
    exp_wptr += (ewe == 2'b11) ? 2 : 1;
    @(posedge clk); #1;
    lvl_valid = 1'b0; lvl_pair = 1'b0;
  endtask

  task automatic end_write(input int num);
    xfer_t t;
    n_vec++;
    if (lvl_ready !== 1'b0 || out_valid !== 1'b0 || buf_re !== 1'b1 || buf_raddr !== 4'd0) begin
      n_err++;
      $display("FAIL prime: got ready=%b valid=%b re=%b raddr=%0d, required 0 0 1 0", lvl_ready, out_valid, buf_re, buf_raddr);
    end
    for (int i = 0; i < num; i += 2) begin
      t.l0   = exp_mem[i];
      t.l1   = (i + 1 < 16) ? exp_mem[i + 1] : 8'h00;
      t.pr   = (num - i >= 2);
      t.last = (num - i <= 2);
      q.push_back(t);
    end
  endtask

  task automatic drain(input logic [3:0] pat, input int plen);
    int k;
    int nd;
    k  = 0;
    nd = n_done;
    while (q.size() != 0 && k < 200) begin
      out_ready = pat[k % plen];
      k++;
      @(posedge clk); #1;
    end
    out_ready = 1'b0;
    n_vec++;
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL drain_timeout: got %0d transfers pending, required 0", q.size());
      q.delete();
    end
    repeat (2) @(posedge clk);
    #1;
    n_vec++;
    if (n_done != nd + 1 || out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL blk_done: got %0d pulses valid=%b, required 1 pulse valid=0", n_done - nd, out_valid);
    end
  endtask

  task automatic test_pair4();
    start_blk(5'd4, 1'b1);
    wr(1'b1, 8'd1, 8'd2, 4);
    wr(1'b1, 8'd3, 8'd4, 4);
    end_write(4);
    drain(4'b1111, 1);
  endtask

  task automatic test_single3();
    start_blk(5'd3, 1'b1);
    wr(1'b0, 8'd5, 8'hEE, 3);
    wr(1'b0, 8'd6, 8'hEE, 3);
    wr(1'b0, 8'd7, 8'hEE, 3);
    end_write(3);
    drain(4'b1111, 1);
  endtask

  task automatic test_stall16();
    start_blk(5'd16, 1'b1);
    for (int i = 0; i < 8; i++) wr(1'b1, 8'(8'h10 + 2 * i), 8'(8'h11 + 2 * i), 16);
    end_write(16);
    drain(4'b1001, 4);
  endtask

  task automatic test_zero_clamp();
    int nd;
    nd = n_done;
    start_blk(5'd0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    n_vec++;
    if (n_done != nd + 1 || out_valid !== 1'b0 || err !== 1'b0) begin
      n_err++;
      $display("FAIL zero_blk: got %0d pulses valid=%b err=%b, required 1 0 0", n_done - nd, out_valid, err);
    end
    start_blk(5'd20, 1'b1);
    n_vec++;
    if (err !== 1'b1) begin
      n_err++;
      $display("FAIL clamp_err: got %b, required 1", err);
    end
    for (int i = 0; i < 8; i++) wr(1'b1, 8'(8'h80 + 2 * i), 8'(8'h81 + 2 * i), 16);
    end_write(16);
    drain(4'b1111, 1);
  endtask

  task automatic test_one_pair();
    do_reset();
    start_blk(5'd1, 1'b1);
    wr(1'b1, 8'h09, 8'hAA, 1);
    n_vec++;
    if (err !== 1'b1) begin
      n_err++;
      $display("FAIL pair_overrun_err: got %b, required 1", err);
    end
    end_write(1);
    drain(4'b1111, 1);
  endtask

  task automatic test_reset_midread();
    int nd;
    do_reset();
    start_blk(5'd4, 1'b1);
    wr(1'b1, 8'h41, 8'h42, 4);
    wr(1'b1, 8'h43, 8'h44, 4);
    end_write(4);
    repeat (3) @(posedge clk);
    #1;
    nd = n_done;
    rst = 1'b1;
    q.delete();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    n_vec++;
    if (out_valid !== 1'b0 || lvl_ready !== 1'b0 || buf_re !== 1'b0) begin
      n_err++;
      $display("FAIL midread_reset: got valid=%b ready=%b re=%b, required 0 0 0", out_valid, lvl_ready, buf_re);
    end
    repeat (3) @(posedge clk);
    #1;
    n_vec++;
    if (n_done != nd) begin
      n_err++;
      $display("FAIL midread_done: got %0d pulses, required 0", n_done - nd);
    end
    start_blk(5'd2, 1'b1);
    wr(1'b1, 8'h51, 8'h52, 2);
    end_write(2);
    drain(4'b1111, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_pair4();
    test_single3();
    test_stall16();
    test_zero_clamp();
    test_one_pair();
    test_reset_midread();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/cavlc_level_ctrl.md
Name: cavlc_level_ctrl

Overview:
Sequencer for the CAVLC two-port level buffer: one level block of 0..16 levels per transaction.
- Write phase: accepts levels (one or two per cycle) from the level-encode stage and drives the buffer write port (waddr, we[1:0], s_all select).
- Read phase: replays the stored levels in ascending address order, in pairs, to the bitstream packer over a valid/ready handshake.
- Sits between the level coder and the CAVLC packer; the buffer itself is instantiated alongside.

Parameters:
DATAW, 8, level width
ADDRW, 4, buffer address width
DEPTH, 16, maximum levels per block; buffer depth

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
start  in  1  begin block; sampled only in IDLE
lvl_num  in  5  level count for block (0..16)
lvl_valid  in  1  upstream data valid
lvl_pair  in  1  1: lvl_in0 and lvl_in1 both valid; 0: lvl_in0 only
lvl_in0  in  DATAW  first level
lvl_in1  in  DATAW  second level
lvl_ready  out  1  controller accepts upstream data
buf_waddr  out  ADDRW  buffer write address
buf_we  out  2  buffer write enables
buf_sel  out  2  buffer s_all; bit0=1 selects in0 for a single write
buf_in0  out  DATAW  equals lvl_in0
buf_in1  out  DATAW  equals lvl_in1
buf_raddr  out  ADDRW  buffer read address; out0=mem[raddr], out1=mem[raddr+1], 1-cycle latency
buf_re  out  1  high in PRIME/READ
buf_out0  in  DATAW  buffer data
buf_out1  in  DATAW  buffer data
out_valid  out  1  output pair valid
out_ready  in  1  packer accepts
out_pair  out  1  both out_lvl0 and out_lvl1 meaningful
out_last  out  1  last transfer of block
out_lvl0  out  DATAW  equals buf_out0
out_lvl1  out  DATAW  equals buf_out1
blk_done  out  1  one-cycle pulse, block finished
err  out  1  sticky protocol error; cleared only by rst

Behaviour:
- Reset (rst=1 at posedge):
  - State to IDLE.
  - Counters, out_valid, blk_done and err to 0.
  - buf_we=0, buf_waddr=0, buf_raddr=0, buf_re=0.
  - Any in-flight block is discarded without a blk_done pulse.
- States: IDLE, WRITE, PRIME, READ.
- IDLE:
  - lvl_ready=0.
  - start with lvl_num=0: blk_done pulses the next cycle; stay in IDLE.
  - start with lvl_num in 1..16: latch num; wptr=0; go to WRITE.
  - lvl_num>16: clamp to 16 and set err.
- WRITE:
  - lvl_ready=1. Write signals are combinational from the handshake fire = lvl_valid & lvl_ready; buf_waddr=wptr.
  - fire & lvl_pair & (num-wptr>=2): buf_we=2'b11; wptr+=2.
  - fire & (!lvl_pair | num-wptr==1): buf_we=2'b01, buf_sel=2'b01; wptr+=1. If lvl_pair was set here, set err; lvl_in1 is dropped.
  - No fire: buf_we=0.
  - When the updated wptr equals num, go to PRIME the next cycle. lvl_ready deasserts in PRIME.
  - start is ignored outside IDLE.
- PRIME:
  - buf_raddr=0, buf_re=1, rd_addr=0.
  - Next state READ with out_valid=1.
- READ:
  - out_valid=1.
  - out_pair = (num-rd_addr>=2).
  - out_last = (num-rd_addr<=2).
  - buf_raddr is combinational: out_ready & !out_last ? rd_addr+2 : rd_addr. This holds buffer outputs stable on stall and gives full throughput, one transfer per cycle.
  - On out_ready & !out_last: rd_addr+=2.
  - On out_ready & out_last: go to IDLE; out_valid=0 next cycle; blk_done pulses the next cycle.
  - Odd num: the final transfer has out_pair=0; out_lvl1 is don't-care (stale buffer word).
- Latency:
  - start accepted to lvl_ready=1: 1 cycle.
  - Last write to first out_valid: 2 cycles (PRIME).
  - N levels stream out in ceil(N/2) accepted cycles.
- Arithmetic:
  - wptr and rd_addr are 5-bit; num≤16 so no wrap.
  - buf_waddr, buf_raddr = low ADDRW bits.
  - A pair write at address 14 touches 14/15 only.
- No writes occur during PRIME/READ; no reads are presented during WRITE.

Test Plan:
- rst held 3 cycles mid-READ -> IDLE; out_valid=0, lvl_ready=0, blk_done never pulses; a new start with lvl_num=2 then works normally.
- start, lvl_num=4, two pair writes (1,2),(3,4), out_ready=1 -> buf_we=11 at waddr 0 then 2; out transfers (1,2,pair,!last),(3,4,pair,last); blk_done 1 cycle after last.
- lvl_num=3, single writes 5,6,7 -> buf_we=01, sel=01 at waddr 0,1,2; out (5,6,pair) then (7,x,!pair,last).
- lvl_num=16, pair writes, out_ready toggling 1,0,0,1 -> outputs held constant while out_ready=0; all 16 values emitted in order; rd_addr never skips.
- lvl_num=0 -> no WRITE/READ, blk_done one pulse; lvl_num=20 -> clamped to 16, err=1.
- lvl_num=1 with lvl_pair=1 -> only lvl_in0 written at address 0, err=1; out (v,x,!pair,last).
